// File: rtl/proc_sequencer.sv
// Instruction sequencer for the 4-register bus processor.
// A host queues 14-bit words {F, Rx, Ry, Data} in a small FIFO.
// The sequencer issues each word with a one-cycle w pulse, then waits for Done.
// It also keeps a retire counter and a Done watchdog with a sticky error flag.
module proc_sequencer #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 6
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [13:0]   InstrIn,
  input  logic          InstrValid,
  output logic          InstrReady,
  input  logic          Go,
  input  logic          ClearErr,
  output logic          w,
  output logic [1:0]    F,
  output logic [1:0]    Rx,
  output logic [1:0]    Ry,
  output logic [7:0]    Data,
  input  logic          Done,
  output logic          Busy,
  output logic          Empty,
  output logic          Full,
  output logic [AW:0]   Count,
  output logic [7:0]    Retired,
  output logic          TimeoutErr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [3:0]  TIMEOUT_L = 4'(TIMEOUT);

  logic [13:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  state_t        state_q;
  logic          w_q;
  logic [1:0]    f_q;
  logic [1:0]    rx_q;
  logic [1:0]    ry_q;
  logic [7:0]    data_q;
  logic [7:0]    retired_q;
  logic          err_q;
  logic [3:0]    wcnt_q;

  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;

  // Occupancy flags come straight from the registered count.
  assign empty_s = (count_q == {(AW+1){1'b0}});
  assign full_s  = (count_q == DEPTH_L);

  // Write and pop qualifiers; a pop only happens on the IDLE->ISSUE step.
  always_comb begin
    push_s = InstrValid & ~full_s;
    if (state_q == ST_IDLE) begin
      pop_s = Go & ~empty_s & ~err_q;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers; the pointers wrap naturally at DEPTH.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 14'd0;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= InstrIn;
        wr_ptr_q        <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      count_q <= count_d;
    end
  end

  // Issue FSM with its registered processor-bus outputs, retire counter and watchdog.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      w_q       <= 1'b0;
      f_q       <= 2'd0;
      rx_q      <= 2'd0;
      ry_q      <= 2'd0;
      data_q    <= 8'd0;
      retired_q <= 8'd0;
      err_q     <= 1'b0;
      wcnt_q    <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            {f_q, rx_q, ry_q, data_q} <= mem_q[rd_ptr_q];
            w_q                       <= 1'b1;
            state_q                   <= ST_ISSUE;
          end else begin
            w_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // Done is deliberately ignored here; the processor has not started yet.
          w_q     <= 1'b0;
          wcnt_q  <= 4'd0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          w_q <= 1'b0;
          if (Done) begin
            retired_q <= retired_q + 8'd1;
            state_q   <= ST_IDLE;
          end else if ((wcnt_q + 4'd1) == TIMEOUT_L) begin
            wcnt_q  <= wcnt_q + 4'd1;
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            wcnt_q <= wcnt_q + 4'd1;
          end
        end
        ST_ERR: begin
          w_q <= 1'b0;
          if (ClearErr) begin
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          w_q     <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign InstrReady = ~full_s;
  assign Empty      = empty_s;
  assign Full       = full_s;
  assign Count      = count_q;
  assign w          = w_q;
  assign F          = f_q;
  assign Rx         = rx_q;
  assign Ry         = ry_q;
  assign Data       = data_q;
  assign Busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign Retired    = retired_q;
  assign TimeoutErr = err_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed, scoreboarded bench for proc_sequencer.
// It includes a behavioural model of the 4-register bus processor.
module tb_proc_sequencer;

  localparam int DEPTH   = 4;
  localparam int AW      = 2;
  localparam int TIMEOUT = 6;

  logic        Clock;
  logic        Reset;
  logic [13:0] InstrIn;
  logic        InstrValid;
  logic        InstrReady;
  logic        Go;
  logic        ClearErr;
  logic        w;
  logic [1:0]  F;
  logic [1:0]  Rx;
  logic [1:0]  Ry;
  logic [7:0]  Data;
  logic        Done;
  logic        Busy;
  logic        Empty;
  logic        Full;
  logic [AW:0] Count;
  logic [7:0]  Retired;
  logic        TimeoutErr;

  proc_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .InstrIn(InstrIn), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Go(Go), .ClearErr(ClearErr), .w(w), .F(F),
    .Rx(Rx), .Ry(Ry), .Data(Data), .Done(Done), .Busy(Busy), .Empty(Empty),
    .Full(Full), .Count(Count), .Retired(Retired), .TimeoutErr(TimeoutErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Processor model: load/move finish in T1; add/sub finish in T3. A stub mode never answers.
  logic       stub;
  logic [1:0] pt;
  logic [7:0] pr [4];

  assign Done = ~stub && (((pt == 2'd1) && !F[1]) || ((pt == 2'd3) && F[1]));

  always @(posedge Clock) begin
    if (Reset) begin
      pt <= 2'd0;
      for (int i = 0; i < 4; i++) pr[i] <= 8'd0;
    end else if (pt == 2'd0) begin
      if (w && !stub) pt <= 2'd1;
    end else if (pt == 2'd1) begin
      if (!F[1]) begin
        pt <= 2'd0;
        if (F[0]) pr[Rx] <= pr[Ry];
        else      pr[Rx] <= Data;
      end else begin
        pt <= 2'd2;
      end
    end else if (pt == 2'd2) begin
      pt <= 2'd3;
    end else begin
      pt <= 2'd0;
      if (F[0]) pr[Rx] <= pr[Rx] - pr[Ry];
      else      pr[Rx] <= pr[Rx] + pr[Ry];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [13:0] sb_q [$];
  int mcount = 0;
  int cyc    = 0;
  int last_w = 0;
  int nw     = 0;
  int ndone  = 0;
  logic w_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] mk(input logic [1:0] f, input logic [1:0] rx,
                                     input logic [1:0] ry, input logic [7:0] d);
    return {f, rx, ry, d};
  endfunction

  // Advance one cycle. Update the scoreboard and check the per-cycle properties.
  task automatic step();
    bit acc;
    acc = InstrValid && (mcount < DEPTH);
    @(posedge Clock);
    #1;
    cyc++;
    if (Reset) begin
      sb_q.delete();
      mcount = 0;
    end else begin
      if (acc) begin
        sb_q.push_back(InstrIn);
        mcount++;
      end
      if (w === 1'b1) begin
        nw++;
        last_w = cyc;
        if (sb_q.size() == 0) begin
          chk("issue_unexpected", 32'(1), 32'(0));
        end else begin
          chk("issue_word", 32'({F, Rx, Ry, Data}), 32'(sb_q.pop_front()));
        end
        mcount--;
      end
      if (Done === 1'b1) begin
        ndone++;
        chk("done_latency", 32'(cyc - last_w), F[1] ? 32'd3 : 32'd1);
      end
    end
    chk("count", 32'(Count), 32'(mcount));
    chk("w_consecutive", 32'(w & w_prev), 32'(0));
    w_prev = w;
  endtask

  task automatic push(input logic [13:0] ins);
    InstrIn    = ins;
    InstrValid = 1'b1;
    step();
    InstrValid = 1'b0;
  endtask

  task automatic wait_retired(input logic [7:0] target, input int budget);
    int n;
    n = 0;
    while (Retired !== target && n < budget) begin
      step();
      n++;
    end
    chk("retired", 32'(Retired), 32'(target));
  endtask

  initial begin
    int nw0;
    int pushed;
    int guard;
    Reset = 1'b1; InstrIn = 14'd0; InstrValid = 1'b0; Go = 1'b0;
    ClearErr = 1'b0; stub = 1'b0;
    step(); step();
    Reset = 1'b0;
    step();
    chk("rst_empty", 32'(Empty), 32'(1));
    chk("rst_full", 32'(Full), 32'(0));
    chk("rst_ready", 32'(InstrReady), 32'(1));
    chk("rst_w", 32'(w), 32'(0));
    chk("rst_busy", 32'(Busy), 32'(0));
    chk("rst_retired", 32'(Retired), 32'(0));
    chk("rst_err", 32'(TimeoutErr), 32'(0));
    chk("rst_bus", 32'({F, Rx, Ry, Data}), 32'(0));

    // Single load R1 = 0x5A
    Go = 1'b1;
    push(mk(2'd0, 2'd1, 2'd0, 8'h5A));
    step();
    chk("t1_w", 32'(w), 32'(1));
    chk("t1_data", 32'(Data), 32'h5A);
    chk("t1_rx", 32'(Rx), 32'(1));
    step();
    chk("t1_busy_wait", 32'(Busy), 32'(1));
    chk("t1_done", 32'(Done), 32'(1));
    step();
    chk("t1_retired", 32'(Retired), 32'(1));
    chk("t1_busy_idle", 32'(Busy), 32'(0));
    chk("t1_r1", 32'(pr[1]), 32'h5A);

    // Fill with Go low; the overflow push is dropped.
    Go = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(2'd0, 2'(i), 2'd0, 8'(8'h10 + i)));
    chk("fill_count", 32'(Count), 32'(4));
    chk("fill_full", 32'(Full), 32'(1));
    chk("fill_ready", 32'(InstrReady), 32'(0));
    push(mk(2'd0, 2'd0, 2'd0, 8'hEE));
    chk("drop_count", 32'(Count), 32'(4));
    Go = 1'b1;
    wait_retired(8'd5, 60);
    chk("drain_empty", 32'(Empty), 32'(1));
    chk("drain_r3", 32'(pr[3]), 32'h13);

    // Arithmetic: R0=3, R1=2, R0+=R1, R0-=R1
    push(mk(2'd0, 2'd0, 2'd0, 8'd3));
    push(mk(2'd0, 2'd1, 2'd0, 8'd2));
    push(mk(2'd2, 2'd0, 2'd1, 8'd0));
    push(mk(2'd3, 2'd0, 2'd1, 8'd0));
    wait_retired(8'd9, 80);
    chk("arith_r0", 32'(pr[0]), 32'h03);

    // Watchdog with a processor that never answers
    stub = 1'b1;
    push(mk(2'd0, 2'd2, 2'd0, 8'h77));
    step();
    chk("to_w", 32'(w), 32'(1));
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      if (k == 1) begin
        InstrIn    = mk(2'd0, 2'd3, 2'd0, 8'h66);
        InstrValid = 1'b1;
      end else begin
        InstrValid = 1'b0;
      end
      step();
      if (k == TIMEOUT)     chk("to_err_before", 32'(TimeoutErr), 32'(0));
      if (k == TIMEOUT + 1) chk("to_err_set", 32'(TimeoutErr), 32'(1));
    end
    InstrValid = 1'b0;
    nw0 = nw;
    repeat (4) step();
    chk("to_no_issue", 32'(nw - nw0), 32'(0));
    chk("to_busy", 32'(Busy), 32'(0));
    chk("to_count", 32'(Count), 32'(1));
    stub = 1'b0;
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;
    chk("to_cleared", 32'(TimeoutErr), 32'(0));
    wait_retired(8'd10, 20);
    chk("to_r3", 32'(pr[3]), 32'h66);

    // Go dropped while an add is in flight
    push(mk(2'd2, 2'd0, 2'd1, 8'd0));
    step();
    chk("go_w", 32'(w), 32'(1));
    Go = 1'b0;
    push(mk(2'd0, 2'd2, 2'd0, 8'h44));
    wait_retired(8'd11, 20);
    nw0 = nw;
    repeat (5) step();
    chk("go_blocked", 32'(nw - nw0), 32'(0));
    chk("go_r0", 32'(pr[0]), 32'h05);
    Go = 1'b1;
    wait_retired(8'd12, 20);
    chk("go_r2", 32'(pr[2]), 32'h44);

    // Reset during WAIT with three entries queued
    stub = 1'b1;
    push(mk(2'd2, 2'd0, 2'd1, 8'd0));
    step();
    for (int i = 0; i < 3; i++) push(mk(2'd0, 2'(i), 2'd0, 8'(i)));
    chk("mid_count", 32'(Count), 32'(3));
    chk("mid_busy", 32'(Busy), 32'(1));
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    stub  = 1'b0;
    chk("mrst_count", 32'(Count), 32'(0));
    chk("mrst_w", 32'(w), 32'(0));
    chk("mrst_busy", 32'(Busy), 32'(0));
    chk("mrst_retired", 32'(Retired), 32'(0));
    chk("mrst_empty", 32'(Empty), 32'(1));

    // 256 loads: the retire counter wraps to zero
    nw0 = nw;
    pushed = 0;
    guard = 0;
    while (guard < 2000 && !(pushed == 256 && (nw - nw0) == 256 && Busy === 1'b0)) begin
      if (pushed < 256 && mcount < DEPTH) begin
        InstrIn    = mk(2'd0, 2'(pushed % 4), 2'd0, 8'(pushed));
        InstrValid = 1'b1;
        pushed++;
      end else begin
        InstrValid = 1'b0;
      end
      step();
      guard++;
    end
    InstrValid = 1'b0;
    step();
    chk("wrap_issued", 32'(nw - nw0), 32'(256));
    chk("wrap_retired", 32'(Retired), 32'(0));
    chk("wrap_empty", 32'(Empty), 32'(1));
    chk("wrap_r3", 32'(pr[3]), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
